aes_dec_iter: RTL

- Iterative AES-128 decryption core: the inverse of the combinational encryption datapath.
- Accepts a 128-bit ciphertext and a 128-bit cipher key over a valid/ready handshake.
- Derives the last round key on chip, then runs the FIPS-197 inverse cipher one round per clock, using the inverse key schedule on the fly.
- Returns the plaintext over a valid/ready output handshake.

---
 rtl/aes_dec_iter_if.sv | 26 ++
 rtl/aes_dec_iter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter_if.sv
// aes_dec_iter_if
// Handshake bundle for the iterative AES-128 decryption core.
//   in_valid / in_ready     : ciphertext + key transfer into the core
//   ciphertext, key         : 128-bit operands, byte 0 in bits [127:120]
//   out_valid / out_ready   : plaintext transfer out of the core
//   plaintext               : 128-bit result, byte 0 in bits [127:120]
// master = block producer/consumer driving the core, slave = the core.
interface aes_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/aes_dec_iter.sv
// aes_dec_iter
// Iterative AES-128 inverse cipher. After accepting a ciphertext/key pair it
// runs the forward key expansion for 10 cycles to reach the last round key,
// then performs one inverse round per cycle while rolling the key schedule
// backwards, and finally presents the plaintext until it is taken.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : aes_dec_iter_if.slave (in_valid/in_ready/ciphertext/key,
//           out_valid/out_ready/plaintext)
// Parameter NR must be 10.
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last expanded key
// so that a repeated key skips the expansion phase (10-edge latency).
module aes_dec_iter #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_dec_iter_if.slave bus
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_dec_iter: only NR=10 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NR - 1);

    state_t       state, next_state;
    logic [127:0] state_reg, key_reg, plain_reg;
    logic [3:0]   cnt;
    logic         in_ready, out_valid, accept, cache_hit;
    logic [7:0]   rc;
    logic [127:0] key_fwd, key_prev, round_out, hit_k10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p, s;
        p = 8'h01;
        s = x;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcv);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcv, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover the earlier round key from the later one.
    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rcv);
        logic [31:0] b0, b1, b2, b3;
        b3 = k[31:0] ^ k[63:32];
        b2 = k[63:32] ^ k[95:64];
        b1 = k[95:64] ^ k[127:96];
        b0 = k[127:96] ^ sub_rot_word(b3) ^ {rcv, 24'h0};
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte i sits at row i%4, column i/4; row r is rotated right by r columns.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic skip_mix);
        logic [127:0] t, m;
        int src;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
            t[127 - 8*i -: 8] = inv_sbox(s[127 - 8*src -: 8]);
        end
        t = t ^ k;
        for (int c = 0; c < 4; c++) begin
            m[127 - 32*c -: 32] = inv_mix_col(t[127 - 32*c -: 32]);
        end
        return skip_mix ? t : m;
    endfunction

    // Expansion and contraction both use Rcon[cnt+1]: while expanding, cnt
    // counts the step being produced; while decrypting, cnt is the round index
    // whose key is being recovered.
    assign rc        = rcon(cnt + 4'd1);
    assign key_fwd   = next_key(key_reg, rc);
    assign key_prev  = prev_key(key_reg, rc);
    assign round_out = inv_round(state_reg, key_prev, cnt == 4'd0);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.plaintext = plain_reg;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key, cache_k10;
    logic         cache_vld;

    assign cache_hit = cache_vld && (bus.key == cache_key);
    assign hit_k10   = cache_k10;

    // Key cache: the incoming key is captured on a miss accept while the valid
    // flag is dropped, and only after the expansion finishes does the pair
    // become usable, so a half-expanded entry can never be hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_key <= '0;
            cache_k10 <= '0;
            cache_vld <= 1'b0;
        end else if (accept && !cache_hit) begin
            cache_key <= bus.key;
            cache_vld <= 1'b0;
        end else if (state == KEXP && cnt == LAST) begin
            cache_k10 <= key_fwd;
            cache_vld <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_k10   = '0;
`endif

    // State register of the control FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs; outputs depend only on the state
    // register, never directly on in_valid or out_ready.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                if (accept) next_state = cache_hit ? ROUND : KEXP;
            end
            KEXP:    if (cnt == LAST) next_state = ROUND;
            ROUND:   if (cnt == 4'd0) next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: loads operands on accept, walks the key forward to k10 while
    // folding in the initial AddRoundKey on the last step, then runs the
    // inverse rounds and latches the result into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            plain_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && cache_hit) begin
                        state_reg <= bus.ciphertext ^ hit_k10;
                        key_reg   <= hit_k10;
                        cnt       <= LAST;
                    end else if (accept) begin
                        state_reg <= bus.ciphertext;
                        key_reg   <= bus.key;
                        cnt       <= 4'd0;
                    end
                end
                KEXP: begin
                    key_reg <= key_fwd;
                    if (cnt == LAST) state_reg <= state_reg ^ key_fwd;
                    else             cnt <= cnt + 4'd1;
                end
                ROUND: begin
                    key_reg   <= key_prev;
                    state_reg <= round_out;
                    if (cnt == 4'd0) plain_reg <= round_out;
                    else             cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
